bus_cycle_control: RTL and testbench

- Sequences each CPU bus cycle after address decode has resolved the target device and port width.
- Generates the 68030 DSACK pair with per-device wait states, and asserts BERR for unmapped accesses and watchdog timeouts.
- Owns the `vector_fetched` flag consumed by `device_decode`: ROM is overlaid at 0 until the reset vector fetch completes.
- Sits between the decode stage and the CPU's DSACK/BERR pins.

---
 rtl/bus_cycle_control.sv | 151 +++++++++++++++
 tb/tb_bus_cycle_control.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_control.sv
// CPU bus cycle sequencer: DSACK generation with per-device wait states,
// BERR on unmapped accesses and watchdog expiry, and the reset-vector overlay flag.
module bus_cycle_control #(
  parameter int unsigned FAST_WAIT     = 1,
  parameter int unsigned SLOW_WAIT     = 4,
  parameter int unsigned TIMEOUT       = 200,
  parameter int unsigned VECTOR_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       as,
  input  logic [1:0] port_width,
  input  logic       slow_device,
  input  logic       cycle_other,
  output logic [1:0] dsack_n,
  output logic       berr_n,
  output logic       vector_fetched,
  output logic       cycle_busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACK    = 3'd2,
    ST_EXTERN = 3'd3,
    ST_BERR   = 3'd4
  } state_t;

  localparam logic [7:0] FAST_LOAD    = 8'(FAST_WAIT);
  localparam logic [7:0] SLOW_LOAD    = 8'(SLOW_WAIT);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] VECTOR_LAST  = 3'(VECTOR_CYCLES - 1);

  state_t     state_r;
  logic [1:0] width_r;
  logic [7:0] wait_cnt_r;
  logic [7:0] watchdog_r;
  logic [2:0] vector_cnt_r;

  // DSACK pins are the inverted port-width code: byte 10, word 01, long 00.
  function automatic logic [1:0] dsack_encode(input logic [1:0] width);
    return ~width;
  endfunction

  // Cycle state machine with registered pin outputs and all cycle counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      width_r        <= 2'b00;
      wait_cnt_r     <= 8'd0;
      watchdog_r     <= 8'd0;
      vector_cnt_r   <= 3'd0;
      dsack_n        <= 2'b11;
      berr_n         <= 1'b1;
      vector_fetched <= 1'b0;
      cycle_busy     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          watchdog_r <= 8'd0;
          dsack_n    <= 2'b11;
          berr_n     <= 1'b1;
          if (as) begin
            cycle_busy <= 1'b1;
            if (cycle_other) begin
              state_r <= ST_EXTERN;
            end else if (port_width == 2'b00) begin
              state_r <= ST_BERR;
              berr_n  <= 1'b0;
            end else begin
              state_r    <= ST_WAIT;
              width_r    <= port_width;
              wait_cnt_r <= slow_device ? SLOW_LOAD : FAST_LOAD;
            end
          end else begin
            cycle_busy <= 1'b0;
          end
        end

        ST_WAIT: begin
          watchdog_r <= watchdog_r + 8'd1;
          if (!as) begin
            state_r    <= ST_IDLE;
            cycle_busy <= 1'b0;
          end else if (watchdog_r == TIMEOUT_LAST) begin
            state_r <= ST_BERR;
            berr_n  <= 1'b0;
          end else if (wait_cnt_r == 8'd0) begin
            state_r <= ST_ACK;
            dsack_n <= dsack_encode(width_r);
          end else begin
            wait_cnt_r <= wait_cnt_r - 8'd1;
          end
        end

        ST_ACK: begin
          if (!as) begin
            state_r    <= ST_IDLE;
            dsack_n    <= 2'b11;
            cycle_busy <= 1'b0;
            // Only completed, self-terminated cycles advance the vector fetch.
            if (!vector_fetched) begin
              vector_cnt_r <= vector_cnt_r + 3'd1;
              if (vector_cnt_r == VECTOR_LAST) begin
                vector_fetched <= 1'b1;
              end else begin
                vector_fetched <= 1'b0;
              end
            end else begin
              vector_fetched <= 1'b1;
            end
          end else begin
            dsack_n <= dsack_encode(width_r);
          end
        end

        ST_EXTERN: begin
          watchdog_r <= watchdog_r + 8'd1;
          if (!as) begin
            state_r    <= ST_IDLE;
            cycle_busy <= 1'b0;
          end else if (watchdog_r == TIMEOUT_LAST) begin
            state_r <= ST_BERR;
            berr_n  <= 1'b0;
          end else begin
            state_r <= ST_EXTERN;
          end
        end

        ST_BERR: begin
          dsack_n <= 2'b11;
          if (!as) begin
            state_r    <= ST_IDLE;
            berr_n     <= 1'b1;
            cycle_busy <= 1'b0;
          end else begin
            berr_n <= 1'b0;
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          dsack_n    <= 2'b11;
          berr_n     <= 1'b1;
          cycle_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_control.sv
// Table-driven bench for bus_cycle_control: expected cycle outcomes are queued
// when a cycle is launched and compared once the cycle has been observed.
module tb_bus_cycle_control;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       as = 1'b0;
  logic [1:0] port_width = 2'b00;
  logic       slow_device = 1'b0;
  logic       cycle_other = 1'b0;
  logic [1:0] dsack_n;
  logic       berr_n;
  logic       vector_fetched;
  logic       cycle_busy;

  bus_cycle_control dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .as             (as),
    .port_width     (port_width),
    .slow_device    (slow_device),
    .cycle_other    (cycle_other),
    .dsack_n        (dsack_n),
    .berr_n         (berr_n),
    .vector_fetched (vector_fetched),
    .cycle_busy     (cycle_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] pw;
    logic       slow;
    logic       other;
    int         hold;      // edges with as high, sampling edge included
    int         ds_lat;    // edges after the sampling edge until DSACK, -1 none
    logic [1:0] ds;
    int         berr_lat;  // edges after the sampling edge until BERR, -1 none
    logic       acked;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   ack_count = 0;
  vec_t exp_q[$];
  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_cycle(input vec_t v, input int idx);
    vec_t       e;
    int         ds_lat = -1;
    int         berr_lat = -1;
    int         ds_cnt = 0;
    int         berr_cnt = 0;
    logic [1:0] ds_first = 2'b11;
    logic       busy0 = 1'b0;
    logic       vf_in = 1'b0;
    exp_q.push_back(v);
    as = 1'b1;
    port_width = v.pw;
    slow_device = v.slow;
    cycle_other = v.other;
    for (int k = 0; k < v.hold; k++) begin
      tick();
      if (k == 0) begin
        busy0 = cycle_busy;
        // Inputs are latched at the sampling edge; disturb them afterwards.
        port_width = ~v.pw;
        slow_device = ~v.slow;
      end
      if (dsack_n != 2'b11) begin
        if (ds_lat < 0) begin
          ds_lat = k;
          ds_first = dsack_n;
        end
        ds_cnt++;
      end
      if (!berr_n) begin
        if (berr_lat < 0) berr_lat = k;
        berr_cnt++;
      end
      vf_in = vector_fetched;
    end
    as = 1'b0;
    cycle_other = 1'b0;
    tick();
    e = exp_q.pop_front();
    check($sformatf("v%0d busy_start", idx), int'(busy0), 1);
    check($sformatf("v%0d dsack_latency", idx), ds_lat, e.ds_lat);
    check($sformatf("v%0d dsack_code", idx), int'(ds_first), int'(e.ds));
    check($sformatf("v%0d dsack_hold", idx), ds_cnt, (e.ds_lat >= 0) ? e.hold - e.ds_lat : 0);
    check($sformatf("v%0d berr_latency", idx), berr_lat, e.berr_lat);
    check($sformatf("v%0d berr_hold", idx), berr_cnt, (e.berr_lat >= 0) ? e.hold - e.berr_lat : 0);
    check($sformatf("v%0d vf_during", idx), int'(vf_in), (ack_count >= 4) ? 1 : 0);
    if (e.acked) ack_count++;
    check($sformatf("v%0d end_dsack", idx), int'(dsack_n), 3);
    check($sformatf("v%0d end_berr", idx), int'(berr_n), 1);
    check($sformatf("v%0d end_busy", idx), int'(cycle_busy), 0);
    check($sformatf("v%0d vf_after", idx), int'(vector_fetched), (ack_count >= 4) ? 1 : 0);
  endtask

  initial begin
    tbl[0] = '{2'b10, 1'b1, 1'b0,   8,  5, 2'b01,  -1, 1'b1};
    tbl[1] = '{2'b10, 1'b1, 1'b0,   8,  5, 2'b01,  -1, 1'b1};
    tbl[2] = '{2'b01, 1'b1, 1'b0,   2, -1, 2'b11,  -1, 1'b0};
    tbl[3] = '{2'b00, 1'b0, 1'b0,   3, -1, 2'b11,   0, 1'b0};
    tbl[4] = '{2'b10, 1'b0, 1'b1,  50, -1, 2'b11,  -1, 1'b0};
    tbl[5] = '{2'b10, 1'b1, 1'b0,   8,  5, 2'b01,  -1, 1'b1};
    tbl[6] = '{2'b10, 1'b1, 1'b0,   8,  5, 2'b01,  -1, 1'b1};
    tbl[7] = '{2'b11, 1'b0, 1'b0,   4,  2, 2'b00,  -1, 1'b1};
    tbl[8] = '{2'b01, 1'b0, 1'b0,   3,  2, 2'b10,  -1, 1'b1};
    tbl[9] = '{2'b10, 1'b0, 1'b1, 250, -1, 2'b11, 200, 1'b0};

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset dsack", int'(dsack_n), 3);
    check("reset berr", int'(berr_n), 1);
    check("reset vf", int'(vector_fetched), 0);
    check("reset busy", int'(cycle_busy), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      do_cycle(tbl[i], i);
    end

    // Asynchronous reset in the middle of an ACK phase.
    as = 1'b1;
    port_width = 2'b10;
    slow_device = 1'b0;
    repeat (3) tick();
    check("pre_reset dsack", int'(dsack_n), 1);
    check("pre_reset vf", int'(vector_fetched), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async dsack", int'(dsack_n), 3);
    check("async berr", int'(berr_n), 1);
    check("async vf", int'(vector_fetched), 0);
    check("async busy", int'(cycle_busy), 0);
    as = 1'b0;
    tick();
    reset_n = 1'b1;
    ack_count = 0;
    tick();
    do_cycle('{2'b10, 1'b0, 1'b0, 4, 2, 2'b01, -1, 1'b1}, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
